pwm_pll_pwm_gen: RTL

Lock-qualified PWM generator that consumes a PLL output clock and its `locked` flag, and drives one PWM pin.
- Software programs it through an Avalon-MM slave: period, duty, enable, polarity.
- Output is held inactive until `locked` has been stable for LOCK_WAIT cycles.
- Output is forced inactive immediately if lock is lost.
- Period/duty changes apply only at a period boundary, so glitch-free updates are guaranteed.

---
 rtl/pwm_pll_pkg.sv | 13 +
 rtl/pwm_pll_lock_qual.sv | 27 ++
 rtl/pwm_pll_pwm_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/pwm_pll_pkg.sv
// pwm_pll_pkg: register map, CTRL/STATUS bit indices and FSM states for the lock-qualified PWM
package pwm_pll_pkg;
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;
    localparam int CTRL_EN   = 0;
    localparam int CTRL_POL  = 1;
    localparam int STAT_LOCK = 0;
    localparam int STAT_RUN  = 1;
    localparam int STAT_LOST = 2;
    typedef enum logic [1:0] {IDLE, WAIT_LOCK, RUN} state_e;
endpackage

// File: rtl/pwm_pll_lock_qual.sv
// pwm_pll_lock_qual: synchronises the PLL lock flag and qualifies it over LOCK_WAIT stable cycles
module pwm_pll_lock_qual import pwm_pll_pkg::*; #(
    parameter int LOCK_WAIT  = 1024,
    parameter int LOCK_CNT_W = 11
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   locked_i,
    input  state_e state_i,
    output logic   lock_s_o,
    output logic   lock_ok_o
);
    logic [1:0]            sync_q;
    logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
    assign lock_s_o  = sync_q[1];
    assign cnt_d     = (state_i == WAIT_LOCK && lock_s_o) ? cnt_q + 1'b1 : '0;
    assign lock_ok_o = lock_s_o && cnt_q == LOCK_CNT_W'(LOCK_WAIT - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], locked_i};
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/pwm_pll_pwm_gen.sv
// pwm_pll_pwm_gen: lock-qualified PWM generator with Avalon-MM period/duty/enable/polarity registers
module pwm_pll_pwm_gen import pwm_pll_pkg::*; #(
    parameter int CNT_W      = 16,
    parameter int LOCK_WAIT  = 1024,
    parameter int LOCK_CNT_W = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        locked,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic        running
);
    state_e           state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_q, period_d, duty_q, duty_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d, sh_duty_q, sh_duty_d, cnt_q, cnt_d;
    logic             lost_q, lost_d, pwm_q, pwm_d, running_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             lock_s, lock_ok, en, load, unused;

    pwm_pll_lock_qual #(.LOCK_WAIT(LOCK_WAIT), .LOCK_CNT_W(LOCK_CNT_W)) u_lock_qual (
        .clk       (clk),
        .rst       (rst),
        .locked_i  (locked),
        .state_i   (state_q),
        .lock_s_o  (lock_s),
        .lock_ok_o (lock_ok)
    );

    assign unused   = ^writedata[31:CNT_W];
    assign readdata = rdata_q;
    assign pwm_out  = pwm_q;
    assign running  = running_q;

    always_comb begin
        en = ctrl_q[CTRL_EN];
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = en ? WAIT_LOCK : IDLE;
            WAIT_LOCK: state_d = !en ? IDLE : (lock_ok ? RUN : WAIT_LOCK);
            RUN:       state_d = !en ? IDLE : (lock_s ? RUN : WAIT_LOCK);
            default:   state_d = IDLE;
        endcase
        lost_d   = (state_q == RUN && !lock_s) ||
                   (lost_q && !(write && address == ADDR_STATUS && writedata[STAT_LOST]));
        ctrl_d   = (write && address == ADDR_CTRL) ? writedata[1:0] : ctrl_q;
        period_d = (write && address == ADDR_PERIOD) ? writedata[CNT_W-1:0] : period_q;
        duty_d   = (write && address == ADDR_DUTY) ? writedata[CNT_W-1:0] : duty_q;
        // shadows take the registered values, so a write on the wrap edge waits a full period
        load        = state_d == RUN && (state_q != RUN || cnt_q == sh_period_q);
        cnt_d       = (state_d == RUN && state_q == RUN && cnt_q != sh_period_q) ? cnt_q + 1'b1 : '0;
        sh_period_d = load ? period_q : sh_period_q;
        sh_duty_d   = load ? duty_q : sh_duty_q;
        pwm_d       = (state_q == RUN && cnt_q < sh_duty_q) ^ ctrl_q[CTRL_POL];
        rdata_d = !read                  ? rdata_q :
                  address == ADDR_CTRL   ? {30'd0, ctrl_q} :
                  address == ADDR_PERIOD ? 32'(period_q) :
                  address == ADDR_DUTY   ? 32'(duty_q) :
                                           {29'd0, lost_q, state_q == RUN, lock_s};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            period_q    <= '0;
            duty_q      <= '0;
            sh_period_q <= '0;
            sh_duty_q   <= '0;
            cnt_q       <= '0;
            lost_q      <= 1'b0;
            pwm_q       <= 1'b0;
            running_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            cnt_q       <= cnt_d;
            lost_q      <= lost_d;
            pwm_q       <= pwm_d;
            running_q   <= state_d == RUN;
            rdata_q     <= rdata_d;
        end
    end
endmodule
